// File: rtl/branch_history_unit.sv
// branch_history_unit: speculative global history with a FIFO of per-branch checkpoints,
// resolved in order at writeback with flush-and-restore on a misprediction.
module branch_history_unit #(
  parameter int DEPTH  = 4,
  parameter int HIST_W = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      fetch_branch,
  input  logic                      fetch_predict_taken,
  input  logic [15:0]               fetch_pc,
  input  logic                      stall,
  input  logic                      resolve_valid,
  input  logic                      resolve_taken,
  output logic [HIST_W-1:0]         spec_history,
  output logic                      update_pattern,
  output logic [15:0]               resolved_pc,
  output logic [HIST_W-1:0]         wb_history,
  output logic                      wb_take_jump,
  output logic                      mispredict,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    inflight_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [15:0]       pc_mem   [DEPTH];
  logic [HIST_W-1:0] hist_mem [DEPTH];
  logic [DEPTH-1:0]  pred_mem;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [HIST_W-1:0] spec_q, spec_d, wb_hist_q;
  logic [15:0]       res_pc_q;
  logic              upd_q, mis_q, take_q;
  logic              push, pop, mis;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign push  = fetch_branch && !stall && !full;
  assign pop   = resolve_valid && !empty;
  assign mis   = pop && (resolve_taken != pred_mem[head_q]);
  // a misprediction flushes everything, so a same-cycle push is discarded
  always_comb begin
    head_d  = mis ? tail_q : head_q + PW'(pop);
    tail_d  = (push && !mis) ? tail_q + PW'(1) : tail_q;
    count_d = mis ? '0 : count_q + CW'(push) - CW'(pop);
    spec_d  = mis  ? {hist_mem[head_q][HIST_W-2:0], resolve_taken} :
              push ? {spec_q[HIST_W-2:0], fetch_predict_taken} : spec_q;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]   <= fetch_pc;
      hist_mem[tail_q] <= spec_q;
      pred_mem[tail_q] <= fetch_predict_taken;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      spec_q    <= '0;
      upd_q     <= 1'b0;
      mis_q     <= 1'b0;
      take_q    <= 1'b0;
      res_pc_q  <= '0;
      wb_hist_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      spec_q  <= spec_d;
      upd_q   <= pop;
      mis_q   <= mis;
      if (pop) begin
        res_pc_q  <= pc_mem[head_q];
        wb_hist_q <= hist_mem[head_q];
        take_q    <= resolve_taken;
      end
    end
  end
  assign spec_history   = spec_q;
  assign update_pattern = upd_q;
  assign resolved_pc    = res_pc_q;
  assign wb_history     = wb_hist_q;
  assign wb_take_jump   = take_q;
  assign mispredict     = mis_q;
  assign inflight_count = count_q;
endmodule

// File: tb/tb_branch_history_unit.sv
// tb_branch_history_unit: directed and random checks of branch_history_unit against a checkpoint-queue model
module tb_branch_history_unit;
  typedef struct packed {logic [15:0] pc; logic [3:0] hist; logic pred;} ent_t;
  typedef struct packed {logic [15:0] pc; logic [3:0] hist; logic tk; logic mis;} exp_t;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        fetch_branch = 1'b0, fetch_predict_taken = 1'b0, stall = 1'b0;
  logic [15:0] fetch_pc = '0;
  logic        resolve_valid = 1'b0, resolve_taken = 1'b0;
  logic [3:0]  spec_history, wb_history;
  logic        update_pattern, wb_take_jump, mispredict, full, empty;
  logic [15:0] resolved_pc;
  logic [2:0]  inflight_count;
  ent_t        mq[$];
  exp_t        exp_q[$];
  logic [3:0]  mh = '0;
  exp_t        last = '0;
  int          tests = 0, fails = 0;

  branch_history_unit #(.DEPTH(4), .HIST_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_branch(fetch_branch),
    .fetch_predict_taken(fetch_predict_taken), .fetch_pc(fetch_pc), .stall(stall),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .spec_history(spec_history), .update_pattern(update_pattern), .resolved_pc(resolved_pc),
    .wb_history(wb_history), .wb_take_jump(wb_take_jump), .mispredict(mispredict),
    .full(full), .empty(empty), .inflight_count(inflight_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(inflight_count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_spec"}, 32'(spec_history), 0);
    chk({tag, "_upd"}, 32'(update_pattern), 0);
    chk({tag, "_mis"}, 32'(mispredict), 0);
    chk({tag, "_rpc"}, 32'(resolved_pc), 0);
    chk({tag, "_wbh"}, 32'(wb_history), 0);
    chk({tag, "_tk"}, 32'(wb_take_jump), 0);
  endtask

  // asynchronous reset asserted away from any clock edge
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_state(tag);
    mq.delete();
    exp_q.delete();
    mh = '0;
    last = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step(input logic fb, input logic pr, input logic [15:0] pc, input logic st,
                      input logic rv, input logic rt);
    logic do_push, do_pop, m;
    ent_t e;
    @(negedge clk);
    fetch_branch = fb; fetch_predict_taken = pr; fetch_pc = pc; stall = st;
    resolve_valid = rv; resolve_taken = rt;
    do_push = fb && !st && (mq.size() != 4);
    do_pop  = rv && (mq.size() != 0);
    m = 1'b0;
    if (do_pop) begin
      e = mq.pop_front();
      m = rt != e.pred;
      exp_q.push_back({e.pc, e.hist, rt, m});
    end
    if (m) begin
      mq.delete();
      mh = {e.hist[2:0], rt};
    end else if (do_push) begin
      mq.push_back({pc, mh, pr});
      mh = {mh[2:0], pr};
    end
    @(posedge clk);
    #1;
    fetch_branch = 1'b0; stall = 1'b0; resolve_valid = 1'b0;
    chk("spec", 32'(spec_history), 32'(mh));
    chk("count", 32'(inflight_count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == 4));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("upd", 32'(update_pattern), 32'(do_pop));
    if (update_pattern) begin
      if (exp_q.size() == 0) chk("upd_unexpected", 32'(update_pattern), 0);
      else begin
        last = exp_q.pop_front();
        chk("rpc", 32'(resolved_pc), 32'(last.pc));
        chk("wbh", 32'(wb_history), 32'(last.hist));
        chk("tk", 32'(wb_take_jump), 32'(last.tk));
        chk("mis", 32'(mispredict), 32'(last.mis));
      end
    end else begin
      chk("mis_idle", 32'(mispredict), 0);
      chk("rpc_hold", 32'(resolved_pc), 32'(last.pc));
      chk("wbh_hold", 32'(wb_history), 32'(last.hist));
      chk("tk_hold", 32'(wb_take_jump), 32'(last.tk));
    end
  endtask

  initial begin
    logic fb, pr, rv, rt;
    #2 chk_reset_state("por");
    @(negedge clk);
    reset_n = 1'b1;
    // first push from reset
    step(1, 1, 16'h3000, 0, 0, 0);
    chk("r32_spec", 32'(spec_history), 32'h1);
    chk("r32_count", 32'(inflight_count), 1);
    chk("r32_empty", 32'(empty), 0);
    // fill to full, fifth push dropped, stalled push ignored
    do_reset("rst_a");
    step(1, 1, 16'h3000, 0, 0, 0);
    step(1, 0, 16'h3002, 0, 0, 0);
    step(1, 1, 16'h3004, 0, 0, 0);
    step(1, 1, 16'h3006, 0, 0, 0);
    chk("r33_spec", 32'(spec_history), 32'hb);
    chk("r33_full", 32'(full), 1);
    step(1, 0, 16'h3008, 0, 0, 0);
    chk("r33_drop_count", 32'(inflight_count), 4);
    chk("r33_drop_spec", 32'(spec_history), 32'hb);
    step(0, 0, 0, 0, 1, 1);
    step(1, 0, 16'h300a, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    // correct taken resolve of a 0x3004 checkpoint with hist 0001
    do_reset("rst_b");
    step(1, 1, 16'h3000, 0, 0, 0);
    step(1, 1, 16'h3004, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("r34_upd", 32'(update_pattern), 1);
    chk("r34_rpc", 32'(resolved_pc), 32'h3004);
    chk("r34_wbh", 32'(wb_history), 32'h1);
    chk("r34_mis", 32'(mispredict), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("r22_upd_pulse", 32'(update_pattern), 0);
    // mispredict with simultaneous push: oldest hist 0010 pred 1
    do_reset("rst_c");
    step(1, 1, 16'h3000, 0, 0, 0);
    step(1, 0, 16'h3002, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    step(1, 1, 16'h3010, 0, 0, 0);
    step(1, 0, 16'h3012, 0, 0, 0);
    step(1, 1, 16'h3014, 0, 0, 0);
    step(1, 1, 16'h3016, 0, 1, 0);
    chk("r35_mis", 32'(mispredict), 1);
    chk("r35_count", 32'(inflight_count), 0);
    chk("r35_spec", 32'(spec_history), 32'h4);
    chk("r35_wbh", 32'(wb_history), 32'h2);
    step(0, 0, 0, 0, 0, 0);
    chk("r22_mis_pulse", 32'(mispredict), 0);
    step(0, 0, 0, 0, 1, 1);
    // full with same-cycle correct pop and push, then wrap-around traffic
    do_reset("rst_d");
    for (int i = 0; i < 4; i++) step(1, 1'(i), 16'(16'h4000 + 2 * i), 0, 0, 0);
    step(1, 1, 16'h4100, 0, 1, 0);
    chk("r36_count", 32'(inflight_count), 3);
    for (int i = 0; i < 40; i++) begin
      fb = 1'($urandom_range(0, 1));
      pr = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      rt = 1'($urandom_range(0, 1));
      if (mq.size() > 0 && $urandom_range(0, 4) != 0) rt = mq[0].pred;
      step(fb, pr, 16'($urandom), 1'($urandom_range(0, 5) == 0), rv, rt);
    end
    // asynchronous reset with entries in flight, then resolve on empty
    do_reset("rst_e");
    step(1, 1, 16'h5000, 0, 0, 0);
    step(1, 0, 16'h5002, 0, 0, 0);
    chk("r37_pre_count", 32'(inflight_count), 2);
    do_reset("r37");
    step(0, 0, 0, 0, 1, 1);
    chk("r37_upd", 32'(update_pattern), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
